// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle PC controller for KGP_RISC.
// Sequences fetch/exec/memory-wait and selects the next PC.
module pc_sequencer #(
    parameter int              PC_W        = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            halt_req,
    input  logic            imem_ready,
    input  logic            is_branch,
    input  logic            branch_taken,
    input  logic            is_jal,
    input  logic            is_ret,
    input  logic [PC_W-1:0] target,
    input  logic [PC_W-1:0] ret_addr,
    input  logic            mem_op,
    input  logic            dmem_done,
    output logic [PC_W-1:0] pc,
    output logic            imem_req,
    output logic            ir_load,
    output logic            exec_en,
    output logic            link_we,
    output logic [PC_W-1:0] link_addr,
    output logic            wrap,
    output logic            err,
    output logic [2:0]      state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_EXEC    = 3'd2,
        S_MEMWAIT = 3'd3,
        S_HALT    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;
    state_t          r_state, w_next;
    logic [PC_W-1:0] r_pc, w_pc_inc, w_pc_nxt;
    logic [7:0]      r_cnt;
    logic            r_imem_req, r_exec_en, r_wrap, r_err;
    logic            w_taken, w_seq, w_timeout;
    assign w_pc_inc  = r_pc + 1'b1;
    assign w_taken   = is_branch && branch_taken;
    assign w_seq     = !is_ret && !is_jal && !w_taken;
    assign w_pc_nxt  = is_ret ? ret_addr : (is_jal || w_taken) ? target : w_pc_inc;
    // counter holds the number of MEMWAIT cycles already completed
    assign w_timeout = r_cnt == 8'(MEM_TIMEOUT - 1);
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = run ? S_FETCH : S_IDLE;
            S_FETCH:   w_next = halt_req ? S_HALT : imem_ready ? S_EXEC : S_FETCH;
            S_EXEC:    w_next = mem_op ? S_MEMWAIT : halt_req ? S_HALT : S_FETCH;
            S_MEMWAIT: w_next = dmem_done ? (halt_req ? S_HALT : S_FETCH) : w_timeout ? S_ERROR : S_MEMWAIT;
            S_HALT:    w_next = run ? S_FETCH : S_HALT;
            S_ERROR:   w_next = S_ERROR;
            default:   w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_cnt      <= '0;
            r_imem_req <= 1'b0;
            r_exec_en  <= 1'b0;
            r_wrap     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= (r_state == S_MEMWAIT) ? r_cnt + 8'd1 : 8'd0;
            r_imem_req <= w_next == S_FETCH;
            r_exec_en  <= w_next == S_EXEC;
            r_err      <= w_next == S_ERROR;
            if (r_state == S_EXEC) r_pc <= w_pc_nxt;
            if (r_state == S_EXEC && w_seq && &r_pc) r_wrap <= 1'b1;
        end
    end
    assign pc        = r_pc;
    assign imem_req  = r_imem_req;
    assign exec_en   = r_exec_en;
    assign ir_load   = (r_state == S_FETCH) && !halt_req && imem_ready;
    assign link_we   = (r_state == S_EXEC) && is_jal && !is_ret;
    assign link_addr = link_we ? w_pc_inc : '0;
    assign wrap      = r_wrap;
    assign err       = r_err;
    assign state     = r_state;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors for pc_sequencer, checked by a queue-fed monitor.
module tb_pc_sequencer;
    logic       clk = 1'b0, rst = 1'b1, run = 1'b0, halt_req = 1'b0, imem_ready = 1'b0;
    logic       is_branch = 1'b0, branch_taken = 1'b0, is_jal = 1'b0, is_ret = 1'b0;
    logic [7:0] target = '0, ret_addr = '0;
    logic       mem_op = 1'b0, dmem_done = 1'b0;
    logic [7:0] pc, link_addr;
    logic       imem_req, ir_load, exec_en, link_we, wrap, err;
    logic [2:0] state;
    int         n_vec = 0, n_bad = 0;
    typedef struct {
        string      name;
        logic [2:0] st;
        logic [7:0] pc;
        logic       ir, lw;
        logic [7:0] la;
        logic       wr, er;
    } exp_t;
    exp_t q[$];
    pc_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .imem_ready(imem_ready),
        .is_branch(is_branch), .branch_taken(branch_taken), .is_jal(is_jal), .is_ret(is_ret),
        .target(target), .ret_addr(ret_addr), .mem_op(mem_op), .dmem_done(dmem_done),
        .pc(pc), .imem_req(imem_req), .ir_load(ir_load), .exec_en(exec_en), .link_we(link_we),
        .link_addr(link_addr), .wrap(wrap), .err(err), .state(state)
    );
    always #5 clk = ~clk;
    task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] req);
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
        end
    endtask
    // monitor: every cycle with a queued expectation is compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            cmp(e.name, "state", 8'(state), 8'(e.st));
            cmp(e.name, "pc", pc, e.pc);
            cmp(e.name, "imem_req", 8'(imem_req), 8'(e.st == 3'd1));
            cmp(e.name, "exec_en", 8'(exec_en), 8'(e.st == 3'd2));
            cmp(e.name, "ir_load", 8'(ir_load), 8'(e.ir));
            cmp(e.name, "link_we", 8'(link_we), 8'(e.lw));
            cmp(e.name, "link_addr", link_addr, e.la);
            cmp(e.name, "wrap", 8'(wrap), 8'(e.wr));
            cmp(e.name, "err", 8'(err), 8'(e.er));
        end
    end
    task automatic chk(input string nm, input logic [2:0] st, input logic [7:0] p, input logic ir,
                       input logic lw, input logic [7:0] la, input logic wr, input logic er);
        exp_t e;
        e.name = nm; e.st = st; e.pc = p; e.ir = ir; e.lw = lw; e.la = la; e.wr = wr; e.er = er;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask
    task automatic fet(input string nm, input logic [7:0] p, input logic wr);
        chk(nm, 3'd1, p, 1'b1, 1'b0, 8'h00, wr, 1'b0);
    endtask
    task automatic exe(input string nm, input logic [7:0] p, input logic lw, input logic [7:0] la, input logic wr);
        chk(nm, 3'd2, p, 1'b0, lw, la, wr, 1'b0);
    endtask
    task automatic mw(input string nm, input logic [7:0] p, input logic wr);
        chk(nm, 3'd3, p, 1'b0, 1'b0, 8'h00, wr, 1'b0);
    endtask
    task automatic clr();
        is_branch = 0; branch_taken = 0; is_jal = 0; is_ret = 0; target = '0; ret_addr = '0;
        mem_op = 0; dmem_done = 0; halt_req = 0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("reset", 3'd0, 8'h00, 0, 0, 8'h00, 0, 0);
        run = 1; imem_ready = 1;
        chk("idle_run", 3'd0, 8'h00, 0, 0, 8'h00, 0, 0);
        for (int k = 0; k < 5; k++) begin
            fet("seq_f", 8'(k), 0);
            exe("seq_e", 8'(k), 0, 8'h00, 0);
        end
        fet("f5", 8'h05, 0);
        is_jal = 1; target = 8'h40;
        exe("jal", 8'h05, 1, 8'h06, 0);
        clr();
        fet("f40", 8'h40, 0);
        is_ret = 1; is_jal = 1; ret_addr = 8'h06; target = 8'h80;
        exe("ret_prio", 8'h40, 0, 8'h00, 0);
        clr();
        fet("f6", 8'h06, 0);
        is_branch = 1; branch_taken = 1; target = 8'h0a;
        exe("br_to10", 8'h06, 0, 8'h00, 0);
        clr();
        fet("f10", 8'h0a, 0);
        is_branch = 1; target = 8'h30;
        exe("br_nt", 8'h0a, 0, 8'h00, 0);
        clr();
        fet("f11", 8'h0b, 0);
        is_branch = 1; branch_taken = 1; target = 8'h03;
        exe("br_t", 8'h0b, 0, 8'h00, 0);
        fet("f3", 8'h03, 0);
        target = 8'hff;
        exe("br_ff", 8'h03, 0, 8'h00, 0);
        clr();
        fet("fff", 8'hff, 0);
        exe("seq_wrap", 8'hff, 0, 8'h00, 0);
        fet("f0_wrap", 8'h00, 1);
        is_branch = 1; branch_taken = 1; target = 8'h20;
        exe("br_keep_wrap", 8'h00, 0, 8'h00, 1);
        clr();
        fet("f20", 8'h20, 1);
        mem_op = 1;
        exe("mem_e", 8'h20, 0, 8'h00, 1);
        clr();
        mw("mw1", 8'h21, 1);
        mw("mw2", 8'h21, 1);
        dmem_done = 1;
        mw("mw3_done", 8'h21, 1);
        clr();
        halt_req = 1;
        chk("f_halt", 3'd1, 8'h21, 0, 0, 8'h00, 1, 0);
        run = 0;
        chk("halt_hold", 3'd4, 8'h21, 0, 0, 8'h00, 1, 0);
        run = 1;
        chk("halt_run", 3'd4, 8'h21, 0, 0, 8'h00, 1, 0);
        halt_req = 0;
        fet("f_resume", 8'h21, 1);
        halt_req = 1;
        exe("e_halt", 8'h21, 0, 8'h00, 1);
        halt_req = 0;
        chk("halt2", 3'd4, 8'h22, 0, 0, 8'h00, 1, 0);
        fet("f22", 8'h22, 1);
        mem_op = 1;
        exe("mem_e2", 8'h22, 0, 8'h00, 1);
        clr();
        for (int k = 0; k < 14; k++) mw("mw_late", 8'h23, 1);
        dmem_done = 1;
        mw("mw_done_at_to", 8'h23, 1);
        clr();
        fet("f23", 8'h23, 1);
        mem_op = 1;
        exe("mem_e3", 8'h23, 0, 8'h00, 1);
        clr();
        for (int k = 0; k < 15; k++) mw("mw_to", 8'h24, 1);
        chk("error1", 3'd5, 8'h24, 0, 0, 8'h00, 1, 1);
        chk("error2", 3'd5, 8'h24, 0, 0, 8'h00, 1, 1);
        rst = 1;
        chk("error_rst", 3'd5, 8'h24, 0, 0, 8'h00, 1, 1);
        rst = 0;
        chk("rst_err", 3'd0, 8'h00, 0, 0, 8'h00, 0, 0);
        fet("r_f0", 8'h00, 0);
        is_branch = 1; branch_taken = 1; target = 8'hff;
        exe("r_br_ff", 8'h00, 0, 8'h00, 0);
        clr();
        fet("r_fff", 8'hff, 0);
        mem_op = 1;
        exe("r_wrap_mem", 8'hff, 0, 8'h00, 0);
        clr();
        mw("r_mw1", 8'h00, 1);
        rst = 1;
        mw("r_mw2_rst", 8'h00, 1);
        rst = 0;
        chk("rst_mw", 3'd0, 8'h00, 0, 0, 8'h00, 0, 0);
        fet("b_f0", 8'h00, 0);
        exe("b_e0", 8'h00, 0, 8'h00, 0);
        fet("b_f1", 8'h01, 0);
        is_branch = 1; branch_taken = 1; target = 8'h00;
        exe("br_to0", 8'h01, 0, 8'h00, 0);
        clr();
        fet("br0_nowrap", 8'h00, 0);
        @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
